// File: rtl/logicnet_pipe_ctrl.sv
// Valid-bit controller for a LAYERS-deep registered LUT pipeline feeding a 2-entry result FIFO; latency LAYERS+1.
// m_ready backpressure ripples back through stage_en to s_ready; `define LOGICNET_STALL_CNT_EN adds stall_cnt.
module logicnet_pipe_ctrl #(
   parameter int LAYERS = 4,
   parameter int OUT_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [LAYERS-1:0] stage_en,
   input  logic [OUT_W-1:0]  dp_out,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [OUT_W-1:0]  m_data,
`ifdef LOGICNET_STALL_CNT_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic [15:0]       out_cnt
);

   logic [LAYERS-1:0] v;
   logic [LAYERS-1:0] free;
   logic [OUT_W-1:0]  fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              fifo_full;
   logic              pop;
   logic              push;
   logic              chain_free;

   assign fifo_full = (fifo_cnt == 2'd2);
   assign m_valid   = (fifo_cnt != 2'd0);
   assign m_data    = fifo_mem[rd_ptr];
   assign pop       = m_valid && m_ready;
   assign push      = v[LAYERS-1] && (!fifo_full || pop);

   // free[i] = !v[i] || (v[i] && free[i+1]) reduces to !v[i] || free[i+1]
   always_comb begin
      free       = '0;
      chain_free = !v[LAYERS-1] || push;
      free[LAYERS-1] = chain_free;
      for (int i = LAYERS - 2; i >= 0; i--) begin
         chain_free = !v[i] || chain_free;
         free[i]    = chain_free;
      end
   end

   assign stage_en = free;
   assign s_ready  = free[0] && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
      end else if (flush) begin
         v <= '0;
      end else begin
         if (free[0]) v[0] <= s_valid && s_ready;
         for (int i = 1; i < LAYERS; i++) begin
            if (free[i]) v[i] <= v[i-1];
         end
      end
   end

   // A full-FIFO push with pop overwrites the slot being read out this cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_mem[0] <= '0;
         fifo_mem[1] <= '0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         fifo_cnt    <= 2'd0;
      end else if (flush) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (push) begin
            fifo_mem[wr_ptr] <= dp_out;
            wr_ptr           <= !wr_ptr;
         end
         if (pop) rd_ptr <= !rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_cnt <= 16'd0;
      end else if (!flush && pop) begin
         out_cnt <= out_cnt + 16'd1;
      end
   end

`ifdef LOGICNET_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= 16'd0;
      end else if (flush) begin
         stall_cnt <= 16'd0;
      end else if (m_valid && !m_ready && stall_cnt != 16'hFFFF) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_logicnet_pipe_ctrl.sv
// Bench for logicnet_pipe_ctrl: identity shift-register datapath, queue scoreboard, per-scenario tasks.
module tb_logicnet_pipe_ctrl;
   localparam int LAYERS = 4;
   localparam int OUT_W  = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              flush = 1'b0;
   logic              s_valid = 1'b0;
   logic              m_ready = 1'b0;
   logic [OUT_W-1:0]  in_data = '0;
   logic              s_ready;
   logic [LAYERS-1:0] stage_en;
   logic [OUT_W-1:0]  dp_out;
   logic              m_valid;
   logic [OUT_W-1:0]  m_data;
   logic [15:0]       out_cnt;
`ifdef LOGICNET_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_acc = 0;
   int n_pop = 0;
   int ord_bad = 0;
   int first_pop = -1;
   int last_pop = -1;
   int exp_cnt = 0;
   logic [OUT_W-1:0] acc_q [$];
   logic [OUT_W-1:0] dp [LAYERS];

   logicnet_pipe_ctrl #(.LAYERS(LAYERS), .OUT_W(OUT_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .stage_en (stage_en),
      .dp_out   (dp_out),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
`ifdef LOGICNET_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .out_cnt  (out_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Datapath stand-in: each stage just forwards the sample tag.
   always @(posedge clk) begin
      if (stage_en[0]) dp[0] <= in_data;
      for (int i = 1; i < LAYERS; i++) begin
         if (stage_en[i]) dp[i] <= dp[i-1];
      end
   end
   assign dp_out = dp[LAYERS-1];

   // Scoreboard: every accepted tag must come out once, in order.
   always @(negedge clk) begin
      if (rst_n && !flush) begin
         if (s_valid && s_ready) begin
            acc_q.push_back(in_data);
            n_acc++;
         end
         if (m_valid && m_ready) begin
            if (acc_q.size() == 0) ord_bad++;
            else if (m_data !== acc_q.pop_front()) ord_bad++;
            n_pop++;
            exp_cnt++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #2;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %0b want 0", m_valid); end
      checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
      checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL reset_out_cnt got %0d want 0", out_cnt); end
      checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %0b want 1", s_ready); end
      checks++; if (stage_en !== {LAYERS{1'b1}}) begin errors++; $display("FAIL reset_stage_en got %b want all ones", stage_en); end
`ifdef LOGICNET_STALL_CNT_EN
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
`endif
      tick(); tick();
      rst_n = 1'b1;
      exp_cnt = 0;
   endtask

   task automatic test_single();
      int cnt0, k;
      cnt0 = exp_cnt;
      ord_bad = 0;
      tick();
      m_ready = 1'b1; s_valid = 1'b1; in_data = 8'h02;
      tick();
      s_valid = 1'b0; in_data = OUT_W'($urandom);
      k = 1;
      while (m_valid !== 1'b1 && k < 20) begin tick(); k++; end
      checks++; if (k !== LAYERS + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", k, LAYERS + 1); end
      checks++; if (m_data !== 8'h02) begin errors++; $display("FAIL single_data got %h want 02", m_data); end
      tick(); tick();
      checks++; if (out_cnt !== 16'(cnt0 + 1)) begin errors++; $display("FAIL single_out_cnt got %0d want %0d", out_cnt, cnt0 + 1); end
      checks++; if (ord_bad !== 0) begin errors++; $display("FAIL single_order got %0d bad want 0", ord_bad); end
   endtask

   task automatic test_back_to_back();
      int a0, p0, cnt0, lowrdy;
      a0 = n_acc; p0 = n_pop; cnt0 = exp_cnt; lowrdy = 0; ord_bad = 0; first_pop = -1;
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         s_valid = 1'b1; in_data = OUT_W'($urandom);
         #1;
         if (s_ready !== 1'b1) lowrdy++;
         tick();
      end
      s_valid = 1'b0;
      repeat (12) tick();
      checks++; if (n_acc - a0 !== 100) begin errors++; $display("FAIL stream_accepts got %0d want 100", n_acc - a0); end
      checks++; if (n_pop - p0 !== 100) begin errors++; $display("FAIL stream_results got %0d want 100", n_pop - p0); end
      checks++; if (last_pop - first_pop !== 99) begin errors++; $display("FAIL stream_gapless span got %0d want 99", last_pop - first_pop); end
      checks++; if (lowrdy !== 0) begin errors++; $display("FAIL stream_s_ready low cycles got %0d want 0", lowrdy); end
      checks++; if (ord_bad !== 0) begin errors++; $display("FAIL stream_order got %0d bad want 0", ord_bad); end
      checks++; if (out_cnt !== 16'(cnt0 + 100)) begin errors++; $display("FAIL stream_out_cnt got %0d want %0d", out_cnt, cnt0 + 100); end
   endtask

   task automatic test_backpressure();
      int a0, p0, bad;
      logic [OUT_W-1:0] head;
      a0 = n_acc; p0 = n_pop; bad = 0; ord_bad = 0;
      tick();
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1; in_data = OUT_W'($urandom);
         tick();
      end
      s_valid = 1'b0;
      checks++; if (n_acc - a0 !== LAYERS + 2) begin errors++; $display("FAIL bp_accepts got %0d want %0d", n_acc - a0, LAYERS + 2); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready got %0b want 0", s_ready); end
      head = (acc_q.size() > 0) ? acc_q[0] : '0;
      repeat (5) begin
         tick();
         if (m_valid !== 1'b1 || m_data !== head) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold_stable got %0d unstable cycles want 0", bad); end
      checks++; if (stage_en !== '0) begin errors++; $display("FAIL bp_stage_en got %b want 0", stage_en); end
      m_ready = 1'b1;
      repeat (15) tick();
      checks++; if (n_pop - p0 !== LAYERS + 2) begin errors++; $display("FAIL bp_results got %0d want %0d", n_pop - p0, LAYERS + 2); end
      checks++; if (ord_bad !== 0) begin errors++; $display("FAIL bp_order got %0d bad want 0", ord_bad); end
   endtask

   task automatic test_flush();
      int cnt0, p0;
      tick();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_valid = 1'b1; in_data = OUT_W'($urandom);
         tick();
      end
      s_valid = 1'b0;
      repeat (4) tick();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_m_valid got %0b want 1", m_valid); end
      cnt0 = exp_cnt; p0 = n_pop;
      flush = 1'b1; m_ready = 1'b1; s_valid = 1'b1;
      #1;
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL flush_s_ready got %0b want 0", s_ready); end
      tick();
      flush = 1'b0; s_valid = 1'b0;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got %0b want 0", m_valid); end
      repeat (10) tick();
      checks++; if (n_pop !== p0) begin errors++; $display("FAIL flush_leftovers got %0d results want 0", n_pop - p0); end
      checks++; if (out_cnt !== 16'(cnt0)) begin errors++; $display("FAIL flush_out_cnt got %0d want %0d", out_cnt, cnt0); end
      acc_q.delete();
   endtask

   task automatic test_async_reset();
      int k;
      logic [OUT_W-1:0] d;
      tick();
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; in_data = OUT_W'($urandom);
         tick();
      end
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL areset_m_valid got %0b want 0", m_valid); end
      checks++; if (m_data !== '0) begin errors++; $display("FAIL areset_m_data got %h want 0", m_data); end
      checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL areset_out_cnt got %0d want 0", out_cnt); end
      checks++; if (stage_en !== {LAYERS{1'b1}} || s_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b/%0b want all ones", stage_en, s_ready); end
      #3 rst_n = 1'b1;
      s_valid = 1'b0;
      acc_q.delete();
      exp_cnt = 0;
      ord_bad = 0;
      tick();
      d = OUT_W'($urandom);
      s_valid = 1'b1; in_data = d;
      tick();
      s_valid = 1'b0;
      k = 1;
      while (m_valid !== 1'b1 && k < 20) begin tick(); k++; end
      checks++; if (k !== LAYERS + 1) begin errors++; $display("FAIL areset_latency got %0d want %0d", k, LAYERS + 1); end
      checks++; if (m_data !== d) begin errors++; $display("FAIL areset_data got %h want %h", m_data, d); end
      tick(); tick();
      checks++; if (out_cnt !== 16'd1) begin errors++; $display("FAIL areset_out_cnt_after got %0d want 1", out_cnt); end
   endtask

   task automatic test_random();
      int a0, p0;
      a0 = n_acc; p0 = n_pop; ord_bad = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         s_valid = 1'($urandom_range(0, 1));
         m_ready = ($urandom_range(0, 3) != 0);
         in_data = OUT_W'($urandom);
      end
      tick();
      s_valid = 1'b0; m_ready = 1'b1;
      repeat (20) tick();
      checks++; if (n_pop - p0 !== n_acc - a0) begin errors++; $display("FAIL random_count got %0d results want %0d", n_pop - p0, n_acc - a0); end
      checks++; if (ord_bad !== 0) begin errors++; $display("FAIL random_order got %0d bad want 0", ord_bad); end
      checks++; if (out_cnt !== 16'(exp_cnt)) begin errors++; $display("FAIL random_out_cnt got %0d want %0d", out_cnt, 16'(exp_cnt)); end
   endtask

`ifdef LOGICNET_STALL_CNT_EN
   task automatic test_stall_cnt();
      int k;
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_clear got %0d want 0", stall_cnt); end
      m_ready = 1'b0; s_valid = 1'b1; in_data = OUT_W'($urandom);
      tick();
      s_valid = 1'b0;
      k = 0;
      while (m_valid !== 1'b1 && k < 20) begin tick(); k++; end
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_wait got m_valid %0b want 1", m_valid); end
      repeat (7) tick();
      checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL stall_count got %0d want 7", stall_cnt); end
      m_ready = 1'b1;
      repeat (3) tick();
      checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL stall_hold got %0d want 7", stall_cnt); end
   endtask
`endif

   task automatic test_wrap();
      int p0;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      acc_q.delete();
      exp_cnt = 0; ord_bad = 0; p0 = n_pop;
      m_ready = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         s_valid = 1'b1; in_data = OUT_W'($urandom);
         tick();
      end
      s_valid = 1'b0;
      repeat (10) tick();
      checks++; if (n_pop - p0 !== 65536) begin errors++; $display("FAIL wrap_results got %0d want 65536", n_pop - p0); end
      checks++; if (out_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_out_cnt got %0d want 0", out_cnt); end
      checks++; if (ord_bad !== 0) begin errors++; $display("FAIL wrap_order got %0d bad want 0", ord_bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_random();
`ifdef LOGICNET_STALL_CNT_EN
      test_stall_cnt();
`endif
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/logicnet_pipe_ctrl.md
LOGICNET_PIPE_CTRL -- requirements
Module: logicnet_pipe_ctrl

Interface
REQ-001 SHALL have parameter LAYERS, default 4: number of registered LUT-layer stages in the controlled datapath (range 1..16).
REQ-002 SHALL have parameter OUT_W, default 2: width of the final-layer datapath output.
REQ-003 SHALL have port clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, 1: synchronous clear of the whole pipeline.
REQ-006 SHALL have port s_valid, input, 1: an input sample is presented to layer 0.
REQ-007 SHALL have port s_ready, output, 1: layer 0 accepts the sample this cycle.
REQ-008 SHALL have port stage_en, output, LAYERS: load enable for each datapath stage register.
REQ-009 SHALL have port dp_out, input, OUT_W: output of the last datapath stage register.
REQ-010 SHALL have port m_valid, output, 1: m_data holds a result.
REQ-011 SHALL have port m_ready, input, 1: the consumer takes m_data.
REQ-012 SHALL have port m_data, output, OUT_W: the classified result.
REQ-013 SHALL have port out_cnt, output, 16: count of delivered results.

Function
REQ-014 SHALL keep one valid bit v[i] per stage, mirroring occupancy of datapath stage i.
REQ-015 SHALL capture results in a 2-entry output FIFO; pop = m_valid && m_ready; push = v[LAYERS-1] && FIFO not full (push when full only if pop happens in the same cycle).
REQ-016 SHALL compute adv[LAYERS-1] = push and adv[i] = v[i] && free[i+1] for i < LAYERS-1, where free[i] = !v[i] || adv[i].
REQ-017 SHALL drive stage_en[i] = free[i] combinationally; a bubble loads when upstream is empty.
REQ-018 SHALL drive s_ready = free[0] with no combinational path from s_valid to s_ready.
REQ-019 SHALL update v[0] <= s_valid && s_ready and v[i] <= v[i-1] when stage_en[i]; otherwise v[i] holds.
REQ-020 SHALL capture dp_out into the FIFO on push; m_data SHALL be the FIFO head, and m_valid SHALL equal FIFO not empty.
REQ-021 SHALL give a latency of LAYERS+1 cycles from the s_valid && s_ready cycle to m_valid, with no backpressure.
REQ-022 SHALL sustain 1 sample/cycle when m_ready is held high.
REQ-023 SHALL keep every stage and the FIFO full with m_valid stable when m_ready is low, and accept nothing once the pipeline is full.
REQ-024 SHALL preserve order; no sample is dropped or duplicated.
REQ-025 SHALL increment out_cnt by 1 on each pop, wrapping from 0xFFFF to 0x0000.
REQ-026 SHALL, on simultaneous push and pop with the FIFO full, pop the head and write the new entry, leaving occupancy at 2.
REQ-027 SHALL, on flush, clear all v[i], FIFO occupancy and pointers on the next edge, and hold s_ready=0 during the flush cycle; out_cnt is unaffected.
REQ-028 SHALL make flush override any same-cycle push, pop or accept; a pop in the flush cycle is not counted.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously clear v[*], FIFO pointers and occupancy, out_cnt=0, m_valid=0 and m_data=0.
REQ-030 SHALL have stage_en and s_ready reflect an empty pipeline (all ones) during reset.
REQ-031 SHALL, on reset mid-operation, lose all in-flight samples, resuming operation on the first edge after rst_n rises.

Configuration
REQ-032 SHALL, with LOGICNET_STALL_CNT_EN defined, add output stall_cnt, 16 bits: saturating count of cycles with m_valid=1 && m_ready=0, cleared by reset or flush.
REQ-033 SHALL, without LOGICNET_STALL_CNT_EN, omit the stall_cnt port and its logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover single sample, LAYERS=4: s_valid pulse at cycle 0, dp_out=2'b10 at the load → m_valid at cycle 5, m_data=2'b10, out_cnt=1 after pop.
REQ-035 SHALL cover streaming: 100 back-to-back samples with m_ready=1 → 100 results in order, no gaps, out_cnt=100.
REQ-036 SHALL cover backpressure: m_ready=0 and 10 offered samples → exactly LAYERS+2=6 accepted, s_ready=0 afterwards; m_ready=1 → 6 results in order.
REQ-037 SHALL cover flush: flush with 3 samples in flight → next cycle m_valid=0 and v all zero; out_cnt unchanged.
REQ-038 SHALL cover async reset: rst_n low mid-stream, pulse not aligned to clk → outputs clear immediately; after release a new sample appears at latency 5.
REQ-039 SHALL cover wrap and stall counter: preset out_cnt traffic to 65536 pops → out_cnt=0; with macro defined, 7 stalled cycles → stall_cnt=7.
